// File: rtl/mem_access.sv
// Load/store controller in front of dual_ram: lane extraction with sign/zero extension,
// read-modify-write for sub-word stores, and misalignment reporting without RAM access.
module mem_access #(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_ren,
    output logic          ram_wen,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_RD,
        S_LD_RSP,
        S_ST_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_ERR
    } state_t;

    state_t        r_state;
    logic          r_ready;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic          r_uns;
    logic [31:0]   r_wdata;

    logic          w_misal;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_ext;
    logic [31:0]   w_merge;
    logic          w_ld_rsp;

    assign w_misal = (req_size == 2'd3)
                   || ((req_size == 2'd1) && req_addr[0])
                   || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    // r_ready mirrors "state is IDLE" but stays low through reset and the edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_ready) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_wdata <= req_wdata;
                        r_ready <= 1'b0;
                        if (w_misal)
                            r_state <= S_ERR;
                        else if (!req_we)
                            r_state <= S_LD_RD;
                        else if (req_size == 2'd2)
                            r_state <= S_ST_WR;
                        else
                            r_state <= S_RMW_RD;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_LD_RD: begin
                    r_state <= S_LD_RSP;
                    r_ready <= 1'b0;
                end
                S_RMW_RD: begin
                    r_state <= S_RMW_WR;
                    r_ready <= 1'b0;
                end
                S_LD_RSP, S_ST_WR, S_RMW_WR, S_ERR: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = ram_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = ram_rdata[7:0];
            2'd1: w_byte = ram_rdata[15:8];
            2'd2: w_byte = ram_rdata[23:16];
            2'd3: w_byte = ram_rdata[31:24];
            default: w_byte = ram_rdata[7:0];
        endcase
        w_half = r_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];

        case (r_size)
            2'd0:    w_ext = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'd1:    w_ext = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_ext = ram_rdata;
        endcase

        w_merge = ram_rdata;
        if (r_size == 2'd0) begin
            case (r_addr[1:0])
                2'd0: w_merge[7:0]   = r_wdata[7:0];
                2'd1: w_merge[15:8]  = r_wdata[7:0];
                2'd2: w_merge[23:16] = r_wdata[7:0];
                2'd3: w_merge[31:24] = r_wdata[7:0];
                default: w_merge = ram_rdata;
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    assign w_ld_rsp  = (r_state == S_LD_RSP) && !r_we;

    assign req_ready = r_ready;
    assign rsp_valid = (r_state == S_LD_RSP) || (r_state == S_ST_WR)
                    || (r_state == S_RMW_WR) || (r_state == S_ERR);
    assign rsp_err   = (r_state == S_ERR);
    assign rsp_rdata = w_ld_rsp ? w_ext : '0;
    assign ram_ren   = (r_state == S_LD_RD) || (r_state == S_RMW_RD);
    assign ram_wen   = (r_state == S_ST_WR) || (r_state == S_RMW_WR);
    assign ram_addr  = r_addr[AW-1:2];
    assign ram_wdata = (r_state == S_ST_WR)  ? r_wdata :
                       (r_state == S_RMW_WR) ? w_merge : '0;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: behavioural RAM, vector table of accesses with a response/write
// scoreboard, plus hand sequences for reset hold and reset during a read-modify-write.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_ren;
    logic        ram_wen;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_access #(.AW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: registered read, read data one cycle after ram_ren.
    logic [31:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        ram_rdata = '0;
    end
    always @(posedge clk) begin
        if (ram_wen) mem[ram_addr[5:0]] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_addr[5:0]];
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wword;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } rsp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("ren_wen_exclusive", {31'd0, ram_ren & ram_wen}, 32'd0);
            if (ram_wen) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h", ram_addr, ram_wdata);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", {2'b00, ram_addr}, {2'b00, w.addr});
                    chk("wr_data", ram_wdata, w.data);
                end
            end else begin
                chk("wdata_idle_zero", ram_wdata, 32'd0);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: err %0b rdata 0x%08h", rsp_err, rsp_rdata);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                    chk("rsp_cycle", cyc, r.due);
                    if (rsp_err) chk("err_no_ram", {30'd0, ram_ren, ram_wen}, 32'd0);
                end
            end else begin
                chk("err_unqualified", {31'd0, rsp_err}, 32'd0);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: req_ready 0 expected 1 within 20 cycles");
        end
    endtask

    task automatic do_req(input vec_t v);
        bit   ok;
        int   lat;
        rsp_t r;
        wait_ready(ok);
        if (ok) begin
            req_valid    = 1'b1;
            req_we       = v.we;
            req_addr     = v.addr;
            req_size     = v.size;
            req_unsigned = v.uns;
            req_wdata    = v.wdata;
            if (v.we && !v.err) wr_q.push_back('{addr: v.addr[31:2], data: v.wword});
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (v.err)                       lat = 0;
            else if (!v.we)                  lat = 1;
            else if (v.size == 2'd2)         lat = 0;
            else                             lat = 1;
            r.err   = v.err;
            r.rdata = v.rdata;
            r.due   = cyc + lat;
            rsp_q.push_back(r);
        end
    endtask

    vec_t vecs[26];

    initial begin
        //            we    addr       sz    uns   wdata          err   rdata          wword
        vecs[0]  = '{1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 32'h12, 2'd0, 1'b0, 32'h0000005A, 1'b0, 32'h0,        32'hDE5ABEEF};
        vecs[3]  = '{1'b0, 32'h12, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0000005A, 32'h0};
        vecs[4]  = '{1'b0, 32'h13, 2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFDE, 32'h0};
        vecs[5]  = '{1'b0, 32'h13, 2'd0, 1'b1, 32'h0,        1'b0, 32'h000000DE, 32'h0};
        vecs[6]  = '{1'b1, 32'h12, 2'd1, 1'b0, 32'h00008001, 1'b0, 32'h0,        32'h8001BEEF};
        vecs[7]  = '{1'b0, 32'h12, 2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFF8001, 32'h0};
        vecs[8]  = '{1'b0, 32'h12, 2'd1, 1'b1, 32'h0,        1'b0, 32'h00008001, 32'h0};
        vecs[9]  = '{1'b0, 32'h11, 2'd2, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 32'h13, 2'd1, 1'b0, 32'h00001234, 1'b1, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 32'h10, 2'd3, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0};
        vecs[12] = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'h8001BEEF, 32'h0};
        vecs[13] = '{1'b1, 32'h10, 2'd0, 1'b0, 32'hAAAAAA77, 1'b0, 32'h0,        32'h8001BE77};
        vecs[14] = '{1'b0, 32'h11, 2'd0, 1'b0, 32'h0,        1'b0, 32'hFFFFFFBE, 32'h0};
        vecs[15] = '{1'b0, 32'h10, 2'd1, 1'b0, 32'h0,        1'b0, 32'hFFFFBE77, 32'h0};
        vecs[16] = '{1'b0, 32'h10, 2'd1, 1'b1, 32'h0,        1'b0, 32'h0000BE77, 32'h0};
        vecs[17] = '{1'b1, 32'h11, 2'd0, 1'b1, 32'h123456C3, 1'b0, 32'h0,        32'h8001C377};
        vecs[18] = '{1'b1, 32'h24, 2'd2, 1'b0, 32'h0F0F1234, 1'b0, 32'h0,        32'h0F0F1234};
        vecs[19] = '{1'b0, 32'h24, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0F0F1234, 32'h0};
        vecs[20] = '{1'b0, 32'h26, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0000000F, 32'h0};
        vecs[21] = '{1'b0, 32'h10, 2'd0, 1'b0, 32'h0,        1'b0, 32'h00000077, 32'h0};
        vecs[22] = '{1'b1, 32'h16, 2'd2, 1'b0, 32'h11111111, 1'b1, 32'h0,        32'h0};
        vecs[23] = '{1'b1, 32'h11, 2'd1, 1'b0, 32'h00002222, 1'b1, 32'h0,        32'h0};
        vecs[24] = '{1'b1, 32'h10, 2'd3, 1'b0, 32'h33333333, 1'b1, 32'h0,        32'h0};
        vecs[25] = '{1'b0, 32'h10, 2'd2, 1'b0, 32'h0,        1'b0, 32'h8001C377, 32'h0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_size = '0;
        req_unsigned = 1'b0;
        req_wdata = '0;

        // Reset held: outputs stay quiet even with req_valid toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_ctrl_outputs", {27'd0, req_ready, ram_ren, ram_wen, rsp_valid, rsp_err}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_ram_addr", {2'b00, ram_addr}, 32'd0);
            chk("rst_ram_wdata", ram_wdata, 32'd0);
            req_valid = ~req_valid;
            req_we = ~req_we;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_low_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 26; i++) do_req(vecs[i]);

        // Reset asserted during RMW_WR of SB 0x00 @0x10: write must be abandoned.
        begin
            bit ok;
            wait_ready(ok);
            if (ok) begin
                req_valid = 1'b1;
                req_we = 1'b1;
                req_addr = 32'h10;
                req_size = 2'd0;
                req_unsigned = 1'b0;
                req_wdata = 32'h0;
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                chk("rmw_rd_ren", {31'd0, ram_ren}, 32'd1);
                chk("rmw_rd_no_wen", {31'd0, ram_wen}, 32'd0);
                @(posedge clk);
                #1;
                chk("rmw_wr_wen", {31'd0, ram_wen}, 32'd1);
                chk("rmw_wr_data", ram_wdata, 32'h8001C300);
                rst = 1'b1;
                #1;
                chk("rst_drops_wen", {31'd0, ram_wen}, 32'd0);
                chk("rst_drops_rsp", {31'd0, rsp_valid}, 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
            end
        end
        do_req('{1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 32'h8001C377, 32'h0});
        do_req('{1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 1'b0, 32'h00000080, 32'h0});

        repeat (5) @(negedge clk);
        chk("rsp_q_drained", rsp_q.size(), 32'd0);
        chk("wr_q_drained", wr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
